// File: rtl/banked_dual_port_mem_if.sv
// CPU-side request/response signals of banked_dual_port_mem; the shared d_bus stays a top-level
// inout because it is resolved against other bus drivers outside this interface.
interface banked_dual_port_mem_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 16
);
  logic              read;
  logic              write;
  logic [ADDR_W-1:0] d_addr;
  logic              d_ready;
  logic [ADDR_W-1:0] i_addr;
  logic [DATA_W-1:0] i_bus;
  logic              i_valid;

  modport master (
    output read, write, d_addr, i_addr,
    input  d_ready, i_bus, i_valid
  );

  modport slave (
    input  read, write, d_addr, i_addr,
    output d_ready, i_bus, i_valid
  );
endinterface

// File: rtl/banked_dual_port_mem.sv
// Dual-port memory: pipelined read-only instruction port plus a wait-stated data port on d_bus.
// Contents are loaded by hierarchical writes; the array is not preloaded.
module banked_dual_port_mem #(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned I_LAT     = 1,
  parameter int unsigned D_WAIT    = 0,
  parameter string       INIT_FILE = "prog.hex"
) (
  input  logic                  clk,
  input  logic                  rst,
  banked_dual_port_mem_if.slave bus,
  inout  wire  [DATA_W-1:0]     d_bus
);

  localparam int unsigned Depth    = 1 << ADDR_W;
  localparam logic [2:0]  WaitInit = 3'(D_WAIT);

  if (I_LAT < 1 || I_LAT > 4) begin : g_bad_i_lat
    $error("banked_dual_port_mem: I_LAT=%0d outside 1..4", I_LAT);
  end
  if (D_WAIT > 7) begin : g_bad_d_wait
    $error("banked_dual_port_mem: D_WAIT=%0d outside 0..7", D_WAIT);
  end

  logic [DATA_W-1:0] mem_q [Depth];

  if (INIT_FILE == "") begin : g_no_preload
  end

  // Instruction port
  logic [DATA_W-1:0] i_pipe_q [I_LAT];
  logic [I_LAT-1:0]  i_vld_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < I_LAT; i++) begin
        i_pipe_q[i] <= '0;
      end
      i_vld_q <= '0;
    end else begin
      i_pipe_q[0] <= mem_q[bus.i_addr];
      for (int i = 1; i < I_LAT; i++) begin
        i_pipe_q[i] <= i_pipe_q[i-1];
      end
      i_vld_q <= (i_vld_q << 1) | I_LAT'(1);
    end
  end

  assign bus.i_bus   = i_pipe_q[I_LAT-1];
  assign bus.i_valid = i_vld_q[I_LAT-1];

  // Data port
  typedef enum logic [1:0] {StIdle, StWait, StDone} d_state_e;

  d_state_e          state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              op_wr_q, op_wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q;

  logic              acc_en;
  logic              acc_we;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_wdata;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_wr_d   = op_wr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    acc_en    = 1'b0;
    acc_we    = op_wr_q;
    acc_addr  = addr_q;
    acc_wdata = wdata_q;

    unique case (state_q)
      StIdle: begin
        if (bus.read || bus.write) begin
          // write wins over a simultaneous read
          op_wr_d = bus.write;
          addr_d  = bus.d_addr;
          if (bus.write) begin
            wdata_d = d_bus;
          end
          if (D_WAIT == 0) begin
            acc_en    = 1'b1;
            acc_we    = bus.write;
            acc_addr  = bus.d_addr;
            acc_wdata = d_bus;
            state_d   = StDone;
          end else begin
            cnt_d   = WaitInit;
            state_d = StWait;
          end
        end
      end
      StWait: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          acc_en  = 1'b1;
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // The array has no reset, so block any access while reset is held.
    if (rst) begin
      acc_en = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      op_wr_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_wr_q <= op_wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      if (acc_en && !acc_we) begin
        rdata_q <= mem_q[acc_addr];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (acc_en && acc_we) begin
      mem_q[acc_addr] <= acc_wdata;
    end
  end

  assign bus.d_ready = (state_q == StDone);
  assign d_bus       = (state_q == StDone && !op_wr_q) ? rdata_q : 'z;

endmodule

// File: tb/tb_banked_dual_port_mem.sv
// Directed bench: dut0 is I_LAT=1/D_WAIT=0, dut1 is I_LAT=3/D_WAIT=3.
module tb_banked_dual_port_mem;
  localparam int unsigned DW = 16;
  localparam int unsigned AW = 16;
  localparam logic [DW-1:0] Sent = 16'h5A5A;

  logic clk;
  logic rst0, rst1;
  int   n_chk, n_fail;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  banked_dual_port_mem_if #(.DATA_W(DW), .ADDR_W(AW)) bus0 ();
  banked_dual_port_mem_if #(.DATA_W(DW), .ADDR_W(AW)) bus1 ();

  wire  [DW-1:0] d_bus0, d_bus1;
  logic          tb_drv0, tb_drv1;
  logic [DW-1:0] tb_dat0, tb_dat1;

  // Bench drives a sentinel whenever the DUT must be hi-Z, so any stray drive corrupts it.
  assign d_bus0 = tb_drv0 ? tb_dat0 : 'z;
  assign d_bus1 = tb_drv1 ? tb_dat1 : 'z;

  banked_dual_port_mem #(.DATA_W(DW), .ADDR_W(AW), .I_LAT(1), .D_WAIT(0)) u_dut0 (
    .clk   (clk),
    .rst   (rst0),
    .bus   (bus0),
    .d_bus (d_bus0)
  );

  banked_dual_port_mem #(.DATA_W(DW), .ADDR_W(AW), .I_LAT(3), .D_WAIT(3)) u_dut1 (
    .clk   (clk),
    .rst   (rst1),
    .bus   (bus1),
    .d_bus (d_bus1)
  );

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    rst0 = 1'b1;
    rst1 = 1'b1;
    bus0.read = 1'b0; bus0.write = 1'b0; bus0.d_addr = '0; bus0.i_addr = '0;
    bus1.read = 1'b0; bus1.write = 1'b0; bus1.d_addr = '0; bus1.i_addr = '0;
    tb_drv0 = 1'b1; tb_dat0 = Sent;
    tb_drv1 = 1'b1; tb_dat1 = Sent;

    u_dut0.mem_q[0] = 16'hFF10;
    u_dut0.mem_q[1] = 16'h0000;
    u_dut0.mem_q[5] = 16'h0000;
    u_dut1.mem_q[0] = 16'h1111;
    u_dut1.mem_q[1] = 16'h2222;
    u_dut1.mem_q[2] = 16'h3333;
    u_dut1.mem_q[3] = 16'h0000;
    u_dut1.mem_q[8] = 16'h0F0F;

    // Reset state
    @(negedge clk);
    chk("rst_i_bus0", bus0.i_bus, 16'h0000);
    chk("rst_i_valid0", 16'(bus0.i_valid), 16'h0);
    chk("rst_d_ready0", 16'(bus0.d_ready), 16'h0);
    chk("rst_d_bus0", d_bus0, Sent);
    chk("rst_i_valid1", 16'(bus1.i_valid), 16'h0);
    chk("rst_d_ready1", 16'(bus1.d_ready), 16'h0);
    rst0 = 1'b0;
    rst1 = 1'b0;

    // Instruction fetch, both latencies
    @(negedge clk);
    chk("t1_i_bus0_a0", bus0.i_bus, 16'hFF10);
    chk("t1_i_valid0", 16'(bus0.i_valid), 16'h1);
    chk("t4_i_valid1_c1", 16'(bus1.i_valid), 16'h0);
    bus0.i_addr = 16'd1;
    bus1.i_addr = 16'd1;
    @(negedge clk);
    chk("t1_i_bus0_a1", bus0.i_bus, 16'h0000);
    chk("t4_i_valid1_c2", 16'(bus1.i_valid), 16'h0);
    bus0.i_addr = 16'd0;
    bus1.i_addr = 16'd2;
    @(negedge clk);
    chk("t1_i_bus0_a0_again", bus0.i_bus, 16'hFF10);
    chk("t4_i_valid1_c3", 16'(bus1.i_valid), 16'h1);
    chk("t4_i_bus1_m0", bus1.i_bus, 16'h1111);
    @(negedge clk);
    chk("t4_i_bus1_m1", bus1.i_bus, 16'h2222);
    @(negedge clk);
    chk("t4_i_bus1_m2", bus1.i_bus, 16'h3333);

    // Zero-wait write then read of addr 8
    bus0.write = 1'b1; bus0.d_addr = 16'd8; tb_dat0 = 16'h00AA;
    @(negedge clk);
    chk("t2_wr_ready", 16'(bus0.d_ready), 16'h1);
    bus0.write = 1'b0; bus0.i_addr = 16'd8; tb_dat0 = Sent;
    @(negedge clk);
    chk("t2_wr_pulse_end", 16'(bus0.d_ready), 16'h0);
    chk("t2_wr_commit", bus0.i_bus, 16'h00AA);
    chk("t2_idle_bus", d_bus0, Sent);
    bus0.read = 1'b1; tb_drv0 = 1'b0;
    @(negedge clk);
    chk("t2_rd_ready", 16'(bus0.d_ready), 16'h1);
    chk("t2_rd_bus", d_bus0, 16'h00AA);
    bus0.read = 1'b0;
    @(posedge clk);
    #1 tb_drv0 = 1'b1;
    @(negedge clk);
    chk("t2_rd_pulse_end", 16'(bus0.d_ready), 16'h0);
    chk("t2_rd_bus_released", d_bus0, Sent);

    // Same-edge write and fetch of addr 5: read-first
    bus0.write = 1'b1; bus0.d_addr = 16'd5; tb_dat0 = 16'h1234; bus0.i_addr = 16'd5;
    @(negedge clk);
    chk("t5_fetch_old", bus0.i_bus, 16'h0000);
    chk("t5_wr_ready", 16'(bus0.d_ready), 16'h1);
    chk("t5_wr_done_undriven", d_bus0, 16'h1234);
    bus0.write = 1'b0; tb_dat0 = Sent;
    @(negedge clk);
    chk("t5_fetch_new", bus0.i_bus, 16'h1234);
    chk("t5_pulse_end", 16'(bus0.d_ready), 16'h0);

    // Three-wait read of addr 8
    bus1.read = 1'b1; bus1.d_addr = 16'd8;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      chk($sformatf("t3_wait%0d_ready", i), 16'(bus1.d_ready), 16'h0);
      chk($sformatf("t3_wait%0d_bus", i), d_bus1, Sent);
    end
    tb_drv1 = 1'b0;
    @(negedge clk);
    chk("t3_rd_ready", 16'(bus1.d_ready), 16'h1);
    chk("t3_rd_bus", d_bus1, 16'h0F0F);
    bus1.read = 1'b0;
    @(posedge clk);
    #1 tb_drv1 = 1'b1;
    @(negedge clk);
    chk("t3_pulse_end", 16'(bus1.d_ready), 16'h0);
    chk("t3_bus_released", d_bus1, Sent);

    // read and write together to addr 3: write wins, bus undriven
    bus1.read = 1'b1; bus1.write = 1'b1; bus1.d_addr = 16'd3; tb_dat1 = 16'h0055;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      chk($sformatf("t6b_wait%0d_ready", i), 16'(bus1.d_ready), 16'h0);
    end
    @(negedge clk);
    chk("t6b_ready", 16'(bus1.d_ready), 16'h1);
    chk("t6b_bus_undriven", d_bus1, 16'h0055);
    bus1.read = 1'b0; bus1.write = 1'b0; tb_dat1 = Sent; bus1.i_addr = 16'd3;
    @(negedge clk);
    chk("t6b_pulse_end", 16'(bus1.d_ready), 16'h0);
    @(negedge clk);
    @(negedge clk);
    chk("t6b_mem3", bus1.i_bus, 16'h0055);

    // Reset during a pending write of addr 2
    bus1.write = 1'b1; bus1.d_addr = 16'd2; tb_dat1 = 16'hBEEF; bus1.i_addr = 16'd2;
    @(negedge clk);
    chk("t6a_wait_ready", 16'(bus1.d_ready), 16'h0);
    rst1 = 1'b1;
    @(negedge clk);
    chk("t6a_rst_ready", 16'(bus1.d_ready), 16'h0);
    chk("t6a_rst_i_valid", 16'(bus1.i_valid), 16'h0);
    chk("t6a_rst_i_bus", bus1.i_bus, 16'h0000);
    rst1 = 1'b0; bus1.write = 1'b0; tb_dat1 = Sent;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      chk($sformatf("t6a_post%0d_ready", i), 16'(bus1.d_ready), 16'h0);
    end
    chk("t6a_i_valid_back", 16'(bus1.i_valid), 16'h1);
    chk("t6a_mem2_fetch", bus1.i_bus, 16'h3333);

    // FSM back in idle: a fresh read of addr 2 completes with normal latency
    bus1.read = 1'b1; bus1.d_addr = 16'd2;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      chk($sformatf("t6a_rd_wait%0d_ready", i), 16'(bus1.d_ready), 16'h0);
    end
    tb_drv1 = 1'b0;
    @(negedge clk);
    chk("t6a_rd_ready", 16'(bus1.d_ready), 16'h1);
    chk("t6a_rd_mem2", d_bus1, 16'h3333);
    bus1.read = 1'b0;
    @(posedge clk);
    #1 tb_drv1 = 1'b1;
    @(negedge clk);
    chk("t6a_rd_pulse_end", 16'(bus1.d_ready), 16'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
